// File: rtl/otf_pkg.sv
// Shared types and constants for the on-the-fly converter.
// Digit encoding follows the {p, n} borrow-save convention.
package otf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] DIG_POS = 2'b10;
  localparam logic [1:0] DIG_NEG = 2'b01;

endpackage

// File: rtl/otf_conv_step.sv
// One Q/QM on-the-fly conversion step for a single signed digit.
// Combinational; shifts drop the MSB.
module otf_conv_step
  import otf_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   dig,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    unique case (1'b1)
      (dig == DIG_POS): begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      (dig == DIG_NEG): begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/otf_converter.sv
// Digit-serial borrow-save to two's-complement converter (Q/QM scheme).
// Define OTF_QM_OUT_EN to expose the registered qm as out_data_m.
module otf_converter
  import otf_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dp,
  input  logic         in_dn,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef OTF_QM_OUT_EN
  output logic [N:0]   out_data_m,
`endif
  output logic [N:0]   out_data
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   q;
  logic [W-1:0]   qm;
  logic [W-1:0]   q_cur;
  logic [W-1:0]   qm_cur;
  logic [W-1:0]   q_next;
  logic [W-1:0]   qm_next;
  logic           accept;
  logic           last;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // A new word starts from q=0, qm=-1 regardless of leftover state.
  assign q_cur  = (state == IDLE) ? '0 : q;
  assign qm_cur = (state == IDLE) ? '1 : qm;
  assign last   = (state == IDLE) ? (N == 1)
                                  : (cnt == CW'(N - 1));

  otf_conv_step #(
    .W (W)
  ) u_step (
    .q       (q_cur),
    .qm      (qm_cur),
    .dig     ({in_dp, in_dn}),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      qm    <= '1;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (accept) begin
            q     <= q_next;
            qm    <= qm_next;
            cnt   <= (state == IDLE) ? CW'(1)
                                     : cnt + CW'(1);
            state <= last ? DONE : RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign out_data = q;
`ifdef OTF_QM_OUT_EN
  assign out_data_m = qm;
`endif

endmodule

// File: tb/tb_otf_converter.sv
// Self-checking bench for otf_converter with N=4.
// Reference: integer sum of d_i * 2^(N-1-i), truncated to N+1 bits.
module tb_otf_converter;

  localparam int N = 4;
  localparam int W = N + 1;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_dp;
  logic         in_dn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef OTF_QM_OUT_EN
  logic [W-1:0] out_data_m;
`endif

  int n_checks;
  int n_fail;

  otf_converter #(
    .N (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dp      (in_dp),
    .in_dn      (in_dn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef OTF_QM_OUT_EN
    .out_data_m (out_data_m),
`endif
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_val(input int d [N]);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) v = v * 2 + d[i];
    return W'(v);
  endfunction

  task automatic set_digit(input int d);
    logic z;
    z = 1'($urandom_range(0, 1));
    if (d > 0) {in_dp, in_dn} = 2'b10;
    else if (d < 0) {in_dp, in_dn} = 2'b01;
    else {in_dp, in_dn} = {z, z};
  endtask

  // Drives k digits with up to maxgap idle cycles before each.
  task automatic drive_digits(input int d [N], input int k,
                              input int maxgap);
    for (int i = 0; i < k; i++) begin
      int g;
      g = $urandom_range(0, maxgap);
      repeat (g) begin
        in_valid = 1'b0;
        {in_dp, in_dn} = 2'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      set_digit(d[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_word(input string name, input int d [N]);
    logic [W-1:0] exp;
    int t;
    exp = ref_val(d);
    t = 0;
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || t != 0) begin
      n_fail++;
      $display("FAIL %s latency: out_valid=%b after %0d extra cycles, required 1 after 0",
               name, out_valid, t);
    end
    n_checks++;
    if (out_data !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %b required %b", name, out_data, exp);
    end
`ifdef OTF_QM_OUT_EN
    n_checks++;
    if (out_data_m !== W'(exp - 1)) begin
      n_fail++;
      $display("FAIL %s data_m: got %b required %b",
               name, out_data_m, W'(exp - 1));
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%b required 1 0 0",
               in_ready, out_valid, out_data);
    end
`ifdef OTF_QM_OUT_EN
    n_checks++;
    if (out_data_m !== '1) begin
      n_fail++;
      $display("FAIL reset data_m: got %b required 11111", out_data_m);
    end
`endif
  endtask

  task automatic test_directed();
    check_word_run("dir_7", '{1, 0, -1, 1});
    check_word_run("dir_m15", '{-1, -1, -1, -1});
    check_word_run("dir_1", '{1, -1, -1, -1});
    check_word_run("dir_zero", '{0, 0, 0, 0});
  endtask

  task automatic check_word_run(input string name, input int d [N]);
    drive_digits(d, N, 0);
    check_word(name, d);
  endtask

  task automatic test_random();
    int d [N];
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 2) - 1;
      drive_digits(d, N, (w < 5) ? 0 : 3);
      check_word($sformatf("rand%0d", w), d);
    end
  endtask

  task automatic test_backpressure();
    int d [N];
    logic [W-1:0] held;
    d = '{1, 1, -1, 0};
    drive_digits(d, N, 0);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      {in_dp, in_dn} = 2'($urandom);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
        n_fail++;
        $display("FAIL bp%0d: out_valid=%b in_ready=%b data=%b required 1 0 %b",
                 c, out_valid, in_ready, out_data, held);
      end
    end
    in_valid = 1'b0;
    check_word("bp_final", d);
  endtask

  task automatic test_flush();
    int d [N];
    d = '{-1, 1, 0, 1};
    drive_digits(d, 2, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: in_ready=%b out_valid=%b required 1 0",
               in_ready, out_valid);
    end
    check_word_run("flush_15", '{1, 1, 1, 1});
    drive_digits(d, 3, 0);
    in_valid = 1'b1;
    set_digit(d[3]);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_last: out_valid=%b in_ready=%b required 0 1",
               out_valid, in_ready);
    end
    check_word_run("after_flush", '{0, -1, 1, 1});
  endtask

  task automatic test_rst_mid();
    drive_digits('{1, -1, 1, 1}, 2, 0);
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    check_word_run("after_rst", '{-1, 0, 0, 1});
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_dp     = 1'b0;
    in_dn     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
